// File: rtl/boundary_param_sequencer.sv
// boundary_param_sequencer
// Stages a tracked corner set, computes its squared width (scale_dist)
// serially on one shared multiplier, validates it, and commits it to the
// renderer-facing shadow registers only on the first clock of the commit
// line, so the renderer sees one constant parameter set for a whole frame.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   VGA_X, VGA_Y          raster position (only VGA_Y is used)
//   corner_valid/ready    handshake for an offered corner set
//   in_{tl,tr,bl,br}_{x,y} offered corners
//   top_left_x..bot_right_y committed corners
//   scale_dist            committed dx^2 + dy^2
//   draw_enable           tracking is fresh; renderer may draw
//   params_updated        one-cycle pulse after a commit
//   reject_count          saturating count of rejected sets
module boundary_param_sequencer #(
  parameter int p_screen_width  = 640,
  parameter int p_screen_height = 480,
  parameter int p_commit_line   = 481,
  parameter int p_stale_frames  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] VGA_X,
  input  logic [10:0] VGA_Y,
  input  logic        corner_valid,
  output logic        corner_ready,
  input  logic [10:0] in_tl_x,
  input  logic [10:0] in_tl_y,
  input  logic [10:0] in_tr_x,
  input  logic [10:0] in_tr_y,
  input  logic [10:0] in_bl_x,
  input  logic [10:0] in_bl_y,
  input  logic [10:0] in_br_x,
  input  logic [10:0] in_br_y,
  output logic [10:0] top_left_x,
  output logic [10:0] top_left_y,
  output logic [10:0] top_right_x,
  output logic [10:0] top_right_y,
  output logic [10:0] bot_left_x,
  output logic [10:0] bot_left_y,
  output logic [10:0] bot_right_x,
  output logic [10:0] bot_right_y,
  output logic [22:0] scale_dist,
  output logic        draw_enable,
  output logic        params_updated,
  output logic [7:0]  reject_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL_X = 3'd1,
    S_MUL_Y = 3'd2,
    S_CHECK = 3'd3,
    S_PEND  = 3'd4
  } state_t;

  state_t      state_q, state_d;

  // Corner arrays are ordered tl_x, tl_y, tr_x, tr_y, bl_x, bl_y, br_x, br_y.
  logic [10:0] stage_q  [8];
  logic [10:0] shadow_q [8];
  logic [10:0] in_c_s   [8];

  logic        line_eq_s, line_eq_q, commit_s;
  logic        take_s, reject_s, accept_s, valid_s;
  logic [22:0] dx2_q, acc_q, scale_q;
  logic [7:0]  reject_q, stale_q, stale_d;
  logic        draw_q, params_q;

  logic signed [11:0] dx_s, dy_s, mul_op_s;
  logic signed [23:0] mul_ext_s;
  logic        [23:0] prod_s;
  logic        [11:0] sum_l_s, sum_r_s, ml_s, mr_s;
  logic               unused_s;

  assign in_c_s[0] = in_tl_x;
  assign in_c_s[1] = in_tl_y;
  assign in_c_s[2] = in_tr_x;
  assign in_c_s[3] = in_tr_y;
  assign in_c_s[4] = in_bl_x;
  assign in_c_s[5] = in_bl_y;
  assign in_c_s[6] = in_br_x;
  assign in_c_s[7] = in_br_y;

  // VGA_X is observability only; the product MSB is always 0 for a square.
  assign unused_s = ^{VGA_X, prod_s[23]};

  // Commit fires only on the first clock the raster sits on the commit line.
  assign line_eq_s = (VGA_Y == 11'(p_commit_line));
  assign commit_s  = line_eq_s & ~line_eq_q;

  // Width and midpoint-height differences; midpoints are summed in 12 bits
  // before halving so the carry is kept.
  assign dx_s    = $signed({1'b0, stage_q[2]} - {1'b0, stage_q[0]});
  assign sum_l_s = {1'b0, stage_q[1]} + {1'b0, stage_q[5]};
  assign sum_r_s = {1'b0, stage_q[3]} + {1'b0, stage_q[7]};
  assign ml_s    = sum_l_s >> 4'd1;
  assign mr_s    = sum_r_s >> 4'd1;
  assign dy_s    = $signed(mr_s - ml_s);

  // One squarer shared between the two multiply states.
  assign mul_op_s  = (state_q == S_MUL_Y) ? dy_s : dx_s;
  assign mul_ext_s = {{12{mul_op_s[11]}}, mul_op_s};
  assign prod_s    = mul_ext_s * mul_ext_s;

  // Set validity: all coordinates on screen and a left-to-right top edge.
  always_comb begin
    valid_s = (stage_q[0] < stage_q[2]);
    for (int i = 0; i < 4; i++) begin
      valid_s = valid_s & (stage_q[2*i] < 11'(p_screen_width))
                        & (stage_q[2*i+1] < 11'(p_screen_height));
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d      = state_q;
    corner_ready = 1'b0;
    accept_s     = 1'b0;
    take_s       = 1'b0;
    reject_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        corner_ready = 1'b1;
        if (corner_valid) begin
          accept_s = 1'b1;
          state_d  = S_MUL_X;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_MUL_X: state_d = S_MUL_Y;
      S_MUL_Y: state_d = S_CHECK;
      S_CHECK: begin
        if (valid_s) begin
          state_d  = S_PEND;
        end else begin
          reject_s = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_PEND: begin
        if (commit_s) begin
          take_s  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_PEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stale counter: cleared by a taken commit, otherwise counts commits.
  always_comb begin
    if (take_s) begin
      stale_d = 8'd0;
    end else if (commit_s && (stale_q < 8'(p_stale_frames))) begin
      stale_d = stale_q + 8'd1;
    end else begin
      stale_d = stale_q;
    end
  end

  // State, line-edge history and stale counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      line_eq_q <= 1'b0;
      stale_q   <= 8'(p_stale_frames);
    end else begin
      state_q   <= state_d;
      line_eq_q <= line_eq_s;
      stale_q   <= stale_d;
    end
  end

  // Staging datapath: capture, dx^2, then dx^2 + dy^2.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) stage_q[i] <= 11'd0;
      dx2_q <= 23'd0;
      acc_q <= 23'd0;
    end else begin
      if (accept_s) stage_q <= in_c_s;
      if (state_q == S_MUL_X) dx2_q <= prod_s[22:0];
      if (state_q == S_MUL_Y) acc_q <= dx2_q + prod_s[22:0];
    end
  end

  // Renderer-facing shadow registers, loaded only by a taken commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) shadow_q[i] <= 11'd0;
      scale_q  <= 23'd0;
      params_q <= 1'b0;
    end else begin
      params_q <= take_s;
      if (take_s) begin
        shadow_q <= stage_q;
        scale_q  <= acc_q;
      end
    end
  end

  // Status: draw gate follows the registered stale count, rejects saturate.
  always_ff @(posedge clk) begin
    if (reset) begin
      draw_q   <= 1'b0;
      reject_q <= 8'd0;
    end else begin
      draw_q <= (stale_q < 8'(p_stale_frames));
      if (reject_s && (reject_q != 8'hFF)) reject_q <= reject_q + 8'd1;
    end
  end

  assign top_left_x     = shadow_q[0];
  assign top_left_y     = shadow_q[1];
  assign top_right_x    = shadow_q[2];
  assign top_right_y    = shadow_q[3];
  assign bot_left_x     = shadow_q[4];
  assign bot_left_y     = shadow_q[5];
  assign bot_right_x    = shadow_q[6];
  assign bot_right_y    = shadow_q[7];
  assign scale_dist     = scale_q;
  assign draw_enable    = draw_q;
  assign params_updated = params_q;
  assign reject_count   = reject_q;

endmodule
